// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch stage.
// Holds the program counter, issues single-outstanding word fetches over a
// request/grant + response-valid memory interface, and presents fetched
// instructions to decode through a valid/ready register slot. A taken
// branch (do_branch) redirects the PC and squashes wrong-path fetches.
//
// Ports:
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   do_branch      : one-cycle redirect request from the branch unit
//   branch_target  : redirect address, sampled with do_branch
//   imem_req/addr  : fetch request and word address (addr = pc_q)
//   imem_gnt       : memory accepts the request this cycle
//   imem_rvalid/rdata : fetch response
//   if_valid/instr/pc : instruction slot towards decode
//   id_ready       : decode consumes the slot this cycle
//   misalign_err   : one-cycle pulse when a redirect target is not word aligned
//   redirect_cnt   : wrapping count of redirects since reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             do_branch,
  input  logic [31:0]      branch_target,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  input  logic             id_ready,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc_q;
  logic [31:0] fetch_pc;
  logic        outstanding;
  logic        drop;
  logic        accept;
  logic        resp;

  // A new fetch is only issued when the slot is free or being drained this
  // cycle, so a returning response always finds the slot empty.
  assign imem_req  = !rst && !do_branch && !outstanding && (!if_valid || id_ready);
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_gnt;
  assign resp      = imem_rvalid && outstanding;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      fetch_pc     <= RESET_PC;
      outstanding  <= 1'b0;
      drop         <= 1'b0;
      if_valid     <= 1'b0;
      if_instr     <= NOP;
      if_pc        <= RESET_PC;
      misalign_err <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      misalign_err <= 1'b0;
      if (resp) outstanding <= 1'b0;

      if (do_branch) begin
        pc_q         <= {branch_target[31:2], 2'b00};
        if_valid     <= 1'b0;
        redirect_cnt <= redirect_cnt + CNT_W'(1);
        misalign_err <= |branch_target[1:0];
        // A response arriving with the redirect is discarded here directly;
        // otherwise the still-pending one must be dropped when it returns.
        if (outstanding && !imem_rvalid) drop <= 1'b1;
        else if (resp)                   drop <= 1'b0;
      end else begin
        if (accept) begin
          outstanding <= 1'b1;
          pc_q        <= pc_q + 32'd4;
          fetch_pc    <= pc_q;
        end
        if (if_valid && id_ready) if_valid <= 1'b0;
        if (resp) begin
          if (drop) begin
            drop <= 1'b0;
          end else begin
            if_valid <= 1'b1;
            if_instr <= imem_rdata;
            if_pc    <= fetch_pc;
          end
        end
      end
    end
  end

endmodule
